// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles both requester handshakes and the memory-side
// command/read-data bus of the shared 1Kx16 memory arbiter.
// slave  = arbiter view; master = requesters + memory view.
interface mem_arbiter_if #(
    parameter int AW = 10,
    parameter int DW = 16
);
    logic          req0,   req1;
    logic          we0,    we1;
    logic [AW-1:0] addr0,  addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          ack0,   ack1;
    logic [DW-1:0] rdata0, rdata1;
    logic          err1;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, err1,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, err1,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of a single-port
// synchronous memory. Each grant runs IDLE -> ACCESS -> RESP, one access per
// 3 cycles, with a one-cycle ack carrying captured read data.
// Optional feature macro: MEM_ARB_WRITE_PROTECT_EN -- blocks port-1 writes
// below PROT_LIMIT and flags them with err1 alongside ack1.
module mem_arbiter #(
    parameter int            AW         = 10,
    parameter int            DW         = 16,
    parameter logic [AW-1:0] PROT_LIMIT = 'h100
) (
    input  logic           clk,
    input  logic           rst,
    mem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state;
    logic          last_grant;  // port granted most recently; reset to 1 so port 0 wins first tie
    logic          sel;         // port owning the in-flight access
    logic          is_rd;       // in-flight access is a read
    logic          blk;         // in-flight access was suppressed by write protection

    logic          elig0, elig1, grant0, grant1;
    logic          c_we, c_blk;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] c_wdata;

    // A request still high in its own ack cycle is the old one, not a new one.
    assign elig0  = bus.req0 & ~bus.ack0;
    assign elig1  = bus.req1 & ~bus.ack1;
    assign grant1 = elig1 & (~elig0 | ~last_grant);
    assign grant0 = elig0 & ~grant1;

    // Command mux for the winning port, plus the protection decision.
    always_comb begin
        c_we    = grant1 ? bus.we1    : bus.we0;
        c_addr  = grant1 ? bus.addr1  : bus.addr0;
        c_wdata = grant1 ? bus.wdata1 : bus.wdata0;
`ifdef MEM_ARB_WRITE_PROTECT_EN
        c_blk   = grant1 & bus.we1 & (bus.addr1 < PROT_LIMIT);
`else
        c_blk   = 1'b0;
`endif
    end

`ifndef MEM_ARB_WRITE_PROTECT_EN
    logic unused_prot;
    assign unused_prot = ^PROT_LIMIT;
`endif

    // Arbitration FSM with registered memory command, acks and read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            sel           <= 1'b0;
            is_rd         <= 1'b0;
            blk           <= 1'b0;
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.ack0      <= 1'b0;
            bus.ack1      <= 1'b0;
            bus.err1      <= 1'b0;
            bus.rdata0    <= '0;
            bus.rdata1    <= '0;
        end else begin
            bus.ack0 <= 1'b0;
            bus.ack1 <= 1'b0;
            bus.err1 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        sel           <= grant1;
                        last_grant    <= grant1;
                        is_rd         <= ~c_we;
                        blk           <= c_blk;
                        bus.mem_en    <= ~c_blk;
                        bus.mem_we    <= c_we & ~c_blk;
                        bus.mem_addr  <= c_addr;
                        bus.mem_wdata <= c_wdata;
                        state         <= ACCESS;
                    end else begin
                        bus.mem_en <= 1'b0;
                        bus.mem_we <= 1'b0;
                    end
                end
                ACCESS: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= RESP;
                end
                RESP: begin
                    if (sel) begin
                        if (is_rd) bus.rdata1 <= bus.mem_rdata;
                        bus.ack1 <= 1'b1;
                        bus.err1 <= blk;
                    end else begin
                        if (is_rd) bus.rdata0 <= bus.mem_rdata;
                        bus.ack0 <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: begin
                    bus.mem_en <= 1'b0;
                    bus.mem_we <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural synchronous 1Kx16
// memory. Inputs change on the falling edge, outputs are sampled there too.
module tb_mem_arbiter;
    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    mem_arbiter_if #(.AW(10), .DW(16)) bus ();

    mem_arbiter #(.AW(10), .DW(16), .PROT_LIMIT(10'h100)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: read data valid the cycle after mem_en.
    logic [15:0] mem [1024];
    always @(posedge clk) begin
        if (rst) begin
            mem[10'h005]  <= 16'hBEEF;
            mem[10'h0FF]  <= 16'h5555;
            bus.mem_rdata <= 16'h0000;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            else            bus.mem_rdata     <= mem[bus.mem_addr];
        end
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.req0 = 0; bus.we0 = 0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 0; bus.we1 = 0; bus.addr1 = '0; bus.wdata1 = '0;
        tick; tick;

        // Reset state
        chk("rst_ack0",  32'(bus.ack0), 0);
        chk("rst_ack1",  32'(bus.ack1), 0);
        chk("rst_err1",  32'(bus.err1), 0);
        chk("rst_rd0",   32'(bus.rdata0), 0);
        chk("rst_rd1",   32'(bus.rdata1), 0);
        chk("rst_en",    32'(bus.mem_en), 0);
        chk("rst_we",    32'(bus.mem_we), 0);
        chk("rst_addr",  32'(bus.mem_addr), 0);
        chk("rst_wdata", 32'(bus.mem_wdata), 0);
        rst = 1'b0;

        // 1: single read of 0x005 by port 0
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h005;
        chk("t1_en_n", 32'(bus.mem_en), 0);
        tick;
        chk("t1_en",   32'(bus.mem_en), 1);
        chk("t1_we",   32'(bus.mem_we), 0);
        chk("t1_addr", 32'(bus.mem_addr), 'h005);
        chk("t1_ack_early", 32'(bus.ack0), 0);
        tick;
        chk("t1_en_off", 32'(bus.mem_en), 0);
        chk("t1_ack_n2", 32'(bus.ack0), 0);
        tick;
        chk("t1_ack0",  32'(bus.ack0), 1);
        chk("t1_rdata", 32'(bus.rdata0), 'hBEEF);
        chk("t1_ack1",  32'(bus.ack1), 0);
        bus.req0 = 0;
        tick;
        chk("t1_ack_pulse", 32'(bus.ack0), 0);
        chk("t1_hold",      32'(bus.rdata0), 'hBEEF);

        // 2: port 1 write 0x1234 to 0x3FF, then read it back
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h3FF; bus.wdata1 = 16'h1234;
        tick;
        chk("t2_en",    32'(bus.mem_en), 1);
        chk("t2_we",    32'(bus.mem_we), 1);
        chk("t2_addr",  32'(bus.mem_addr), 'h3FF);
        chk("t2_wdata", 32'(bus.mem_wdata), 'h1234);
        tick;
        chk("t2_we_off", 32'(bus.mem_we), 0);
        tick;
        chk("t2_ack1", 32'(bus.ack1), 1);
        chk("t2_err1", 32'(bus.err1), 0);
        chk("t2_rd_unch", 32'(bus.rdata1), 0);
        bus.req1 = 0;
        tick;
        bus.req1 = 1; bus.we1 = 0;
        tick;
        chk("t2r_en", 32'(bus.mem_en), 1);
        chk("t2r_we", 32'(bus.mem_we), 0);
        tick; tick;
        chk("t2r_ack1",  32'(bus.ack1), 1);
        chk("t2r_rdata", 32'(bus.rdata1), 'h1234);
        chk("t2r_mem",   32'(mem[10'h3FF]), 'h1234);
        bus.req1 = 0;
        tick;

        // 3: contention, 4 reads each; port 0 first, then strict alternation
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h005;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h3FF;
        for (int k = 1; k <= 24; k++) begin
            tick;
            chk($sformatf("t3_ack0_%0d", k), 32'(bus.ack0), 32'((k % 6) == 3));
            chk($sformatf("t3_ack1_%0d", k), 32'(bus.ack1), 32'((k % 6) == 0));
            if ((k % 3) == 1) begin
                chk($sformatf("t3_en_%0d", k), 32'(bus.mem_en), 1);
                chk($sformatf("t3_addr_%0d", k), 32'(bus.mem_addr),
                    ((k % 6) == 1) ? 32'h005 : 32'h3FF);
            end
            if (k == 21) bus.req0 = 0;
            if (k == 24) bus.req1 = 0;
        end
        tick;
        chk("t3_idle",  32'(bus.mem_en), 0);
        chk("t3_rd0",   32'(bus.rdata0), 'hBEEF);
        chk("t3_rd1",   32'(bus.rdata1), 'h1234);

        // 4: req0 held through its ack; next grant starts one cycle later
        bus.req0 = 1; bus.addr0 = 10'h005;
        tick;
        chk("t4_en1", 32'(bus.mem_en), 1);
        tick; tick;
        chk("t4_ack_a", 32'(bus.ack0), 1);
        tick;
        chk("t4_no_en_ack", 32'(bus.mem_en), 0);
        chk("t4_ack_off",   32'(bus.ack0), 0);
        tick;
        chk("t4_en2", 32'(bus.mem_en), 1);
        tick; tick;
        chk("t4_ack_b", 32'(bus.ack0), 1);
        bus.req0 = 0;
        tick;
        chk("t4_idle", 32'(bus.mem_en), 0);

        // 5: reset during ACCESS abandons the access; tie afterwards goes to port 0
        bus.req0 = 1; bus.addr0 = 10'h005;
        tick;
        chk("t5_en", 32'(bus.mem_en), 1);
        rst = 1; bus.req0 = 0;
        tick;
        chk("t5_en_off", 32'(bus.mem_en), 0);
        chk("t5_we_off", 32'(bus.mem_we), 0);
        chk("t5_ack0",   32'(bus.ack0), 0);
        chk("t5_rd0",    32'(bus.rdata0), 0);
        chk("t5_rd1",    32'(bus.rdata1), 0);
        chk("t5_addr",   32'(bus.mem_addr), 0);
        rst = 0;
        tick;
        chk("t5_noack", 32'(bus.ack0), 0);
        bus.req0 = 1; bus.we0 = 0; bus.addr0 = 10'h005;
        bus.req1 = 1; bus.we1 = 0; bus.addr1 = 10'h3FF;
        tick;
        chk("t5_tie_addr", 32'(bus.mem_addr), 'h005);
        tick; tick;
        chk("t5_ack0b", 32'(bus.ack0), 1);
        chk("t5_rd0b",  32'(bus.rdata0), 'hBEEF);
        bus.req0 = 0;
        tick; tick; tick;
        chk("t5_ack1b", 32'(bus.ack1), 1);
        chk("t5_rd1b",  32'(bus.rdata1), 'h1234);
        bus.req1 = 0;
        tick;

        // 6: port-1 write to 0x0FF (protected region when the feature is on)
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h0FF; bus.wdata1 = 16'hAAAA;
        tick;
`ifdef MEM_ARB_WRITE_PROTECT_EN
        chk("t6_en_blk", 32'(bus.mem_en), 0);
        chk("t6_we_blk", 32'(bus.mem_we), 0);
`else
        chk("t6_en", 32'(bus.mem_en), 1);
        chk("t6_we", 32'(bus.mem_we), 1);
`endif
        tick; tick;
        chk("t6_ack1", 32'(bus.ack1), 1);
`ifdef MEM_ARB_WRITE_PROTECT_EN
        chk("t6_err1", 32'(bus.err1), 1);
`else
        chk("t6_err1", 32'(bus.err1), 0);
`endif
        chk("t6_rd1", 32'(bus.rdata1), 'h1234);
        bus.req1 = 0;
        tick;
        chk("t6_err_pulse", 32'(bus.err1), 0);
`ifdef MEM_ARB_WRITE_PROTECT_EN
        chk("t6_mem", 32'(mem[10'h0FF]), 'h5555);
`else
        chk("t6_mem", 32'(mem[10'h0FF]), 'hAAAA);
`endif
        bus.req1 = 1; bus.we1 = 1; bus.addr1 = 10'h100; bus.wdata1 = 16'h7777;
        tick;
        chk("t6b_we", 32'(bus.mem_we), 1);
        tick; tick;
        chk("t6b_ack1", 32'(bus.ack1), 1);
        chk("t6b_err1", 32'(bus.err1), 0);
        bus.req1 = 0;
        tick;
        chk("t6b_mem", 32'(mem[10'h100]), 'h7777);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
